// File: rtl/arb_update_ctrl.sv
// Run controller for the arbitrage graph: buffers edge updates, writes each one into
// AdjMat as a forward/reverse pair, then sequences Bellman and optional CycleDetect runs.
module arb_update_ctrl #(
  parameter int NUM_VERT   = 32,
  parameter int VID_W      = 5,
  parameter int W_W        = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int BATCH      = 4,
  parameter int DO_CYCLE   = 1,
  parameter int TIMEOUT    = 65535
) (
  input  logic                    clk,
  input  logic                    ctrl_reset,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [VID_W-1:0]        upd_src,
  input  logic [VID_W-1:0]        upd_dst,
  input  logic signed [W_W-1:0]   upd_w,
  output logic                    adj_we,
  output logic [VID_W-1:0]        adj_row,
  output logic [VID_W-1:0]        adj_col,
  output logic signed [W_W-1:0]   adj_data,
  output logic                    bellman_reset,
  input  logic                    bellman_done,
  input  logic [VID_W-1:0]        bellman_row,
  input  logic [VID_W-1:0]        bellman_col,
  output logic                    cycle_reset,
  input  logic                    cycle_done,
  input  logic [VID_W-1:0]        cycle_row,
  input  logic [VID_W-1:0]        cycle_col,
  output logic                    busy,
  output logic                    run_done,
  output logic                    run_timeout,
  output logic [7:0]              drop_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BC_W  = $clog2(BATCH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int E_W   = 2 * VID_W + W_W;

  typedef enum logic [2:0] {
    IDLE, WR_FWD, WR_REV, START_BF, RUN_BF, START_CD, RUN_CD, FIN
  } state_t;

  state_t state, state_nxt;

  logic [E_W-1:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [BC_W-1:0]         bcnt, bcnt_inc;
  logic [WD_W-1:0]         wdog;
  logic [VID_W-1:0]        cur_src, cur_dst, head_src, head_dst;
  logic signed [W_W-1:0]   cur_w, head_w;
  logic                    empty, full, id_ok, xfer, accept;
  logic                    bypass, pop, push, load, more_rev;
  logic                    run_state, timeout_hit, first_run_cyc;

  function automatic logic signed [W_W-1:0] neg_sat(input logic signed [W_W-1:0] x);
    if (x == {1'b1, {(W_W-1){1'b0}}})
      return {1'b0, {(W_W-1){1'b1}}};
    return -x;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign upd_ready = !full;
  assign xfer      = upd_valid && upd_ready;
  assign id_ok     = (upd_src != upd_dst) && (32'(upd_src) < 32'(NUM_VERT)) &&
                     (32'(upd_dst) < 32'(NUM_VERT));
  assign accept    = xfer && id_ok;
  assign bcnt_inc  = bcnt + BC_W'(1);
  assign more_rev  = !empty && (bcnt_inc < BC_W'(BATCH));

  // An update arriving at an idle, empty controller skips the FIFO so its first write
  // lands in the very next cycle.
  assign bypass = (state == IDLE) && empty && accept && (bcnt < BC_W'(BATCH));
  assign pop    = ((state == IDLE) && !empty && (bcnt < BC_W'(BATCH))) ||
                  ((state == WR_REV) && more_rev);
  assign push   = accept && !bypass;
  assign load   = pop || bypass;

  assign {head_src, head_dst, head_w} = mem[rd_ptr];

  assign run_state     = (state == RUN_BF) || (state == RUN_CD);
  assign timeout_hit   = run_state && (wdog == WD_W'(TIMEOUT));
  // Done is still the previous run's level during the first cycle after a start pulse.
  assign first_run_cyc = (wdog == '0);

  always_ff @(posedge clk) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load) state_nxt = WR_FWD;
      WR_FWD:   state_nxt = WR_REV;
      WR_REV:   state_nxt = more_rev ? WR_FWD : START_BF;
      START_BF: state_nxt = RUN_BF;
      RUN_BF: begin
        if (timeout_hit)
          state_nxt = FIN;
        else if (bellman_done && !first_run_cyc)
          state_nxt = (DO_CYCLE != 0) ? START_CD : FIN;
      end
      START_CD: state_nxt = RUN_CD;
      RUN_CD: begin
        if (timeout_hit || (cycle_done && !first_run_cyc))
          state_nxt = FIN;
      end
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    adj_we        = 1'b0;
    adj_row       = '0;
    adj_col       = '0;
    adj_data      = '0;
    bellman_reset = 1'b0;
    cycle_reset   = 1'b0;
    run_done      = 1'b0;
    case (state)
      WR_FWD: begin
        adj_we   = 1'b1;
        adj_row  = cur_src;
        adj_col  = cur_dst;
        adj_data = cur_w;
      end
      WR_REV: begin
        adj_we   = 1'b1;
        adj_row  = cur_dst;
        adj_col  = cur_src;
        adj_data = neg_sat(cur_w);
      end
      START_BF: bellman_reset = 1'b1;
      RUN_BF: begin
        adj_row = bellman_row;
        adj_col = bellman_col;
      end
      START_CD: cycle_reset = 1'b1;
      RUN_CD: begin
        adj_row = cycle_row;
        adj_col = cycle_col;
      end
      FIN:      run_done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bcnt        <= '0;
      wdog        <= '0;
      run_timeout <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (state == WR_REV)   bcnt <= bcnt_inc;
      else if (state == FIN) bcnt <= '0;
      if ((state == START_BF) || (state == START_CD)) wdog <= '0;
      else if (run_state)                             wdog <= wdog + WD_W'(1);
      if (timeout_hit) run_timeout <= 1'b1;
      if (xfer && !id_ok) drop_count <= sat_inc8(drop_count);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {upd_src, upd_dst, upd_w};
    if (load) begin
      cur_src <= pop ? head_src : upd_src;
      cur_dst <= pop ? head_dst : upd_dst;
      cur_w   <= pop ? head_w   : upd_w;
    end
  end

endmodule

// File: tb/tb_arb_update_ctrl.sv
// Directed bench for arb_update_ctrl: one instance with CycleDetect, one without,
// sharing stimulus; simple engine models answer the start pulses.
module tb_arb_update_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ctrl_reset, upd_valid;
  logic [5:0]        upd_src, upd_dst;
  logic signed [31:0] upd_w;
  logic              bellman_done, cycle_done;
  logic [5:0]        bellman_row, bellman_col, cycle_row, cycle_col;

  logic              upd_ready, adj_we, bellman_reset, cycle_reset, busy, run_done, run_timeout;
  logic [5:0]        adj_row, adj_col;
  logic signed [31:0] adj_data;
  logic [7:0]        drop_count;

  logic              ready_nc, we_nc, bres_nc, cres_nc, busy_nc, done_nc, tout_nc;
  logic [5:0]        row_nc, col_nc;
  logic signed [31:0] data_nc;
  logic [7:0]        drop_nc;

  arb_update_ctrl #(.NUM_VERT(32), .VID_W(6), .W_W(32), .FIFO_DEPTH(8), .BATCH(4),
                    .DO_CYCLE(1), .TIMEOUT(100)) dut (
    .clk(clk), .ctrl_reset(ctrl_reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_src(upd_src), .upd_dst(upd_dst), .upd_w(upd_w),
    .adj_we(adj_we), .adj_row(adj_row), .adj_col(adj_col), .adj_data(adj_data),
    .bellman_reset(bellman_reset), .bellman_done(bellman_done),
    .bellman_row(bellman_row), .bellman_col(bellman_col),
    .cycle_reset(cycle_reset), .cycle_done(cycle_done),
    .cycle_row(cycle_row), .cycle_col(cycle_col),
    .busy(busy), .run_done(run_done), .run_timeout(run_timeout), .drop_count(drop_count)
  );

  arb_update_ctrl #(.NUM_VERT(32), .VID_W(6), .W_W(32), .FIFO_DEPTH(8), .BATCH(4),
                    .DO_CYCLE(0), .TIMEOUT(100)) dut_nc (
    .clk(clk), .ctrl_reset(ctrl_reset), .upd_valid(upd_valid), .upd_ready(ready_nc),
    .upd_src(upd_src), .upd_dst(upd_dst), .upd_w(upd_w),
    .adj_we(we_nc), .adj_row(row_nc), .adj_col(col_nc), .adj_data(data_nc),
    .bellman_reset(bres_nc), .bellman_done(bellman_done),
    .bellman_row(bellman_row), .bellman_col(bellman_col),
    .cycle_reset(cres_nc), .cycle_done(cycle_done),
    .cycle_row(cycle_row), .cycle_col(cycle_col),
    .busy(busy_nc), .run_done(done_nc), .run_timeout(tout_nc), .drop_count(drop_nc)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_bf, n_cd, n_done, n_done_nc, n_cd_nc;
  int bf_dly, bf_cnt, cd_dly, cd_cnt;
  bit bf_auto;
  int bf_lat = 3;
  int cd_lat = 3;
  int wr_rc[$];
  logic [31:0] wr_d[$];
  int wr_bf[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_rc.delete(); wr_d.delete(); wr_bf.delete();
    n_bf = 0; n_cd = 0; n_done = 0; n_done_nc = 0; n_cd_nc = 0;
  endtask

  // One clock: sample just after the edge, log activity, then advance the engine models.
  // Done drops two samples after the start pulse, so it is stale in the first RUN cycle.
  task automatic tick();
    @(posedge clk); #1;
    if (adj_we) begin
      wr_rc.push_back(int'(adj_row) * 64 + int'(adj_col));
      wr_d.push_back(adj_data);
      wr_bf.push_back(n_bf);
    end
    n_bf      += int'(bellman_reset);
    n_cd      += int'(cycle_reset);
    n_done    += int'(run_done);
    n_done_nc += int'(done_nc);
    n_cd_nc   += int'(cres_nc);
    if (bf_dly > 0) begin
      bf_dly--;
      if (bf_dly == 0) begin bellman_done = 1'b0; bf_cnt = bf_lat; end
    end else if (bf_cnt > 0) begin
      bf_cnt--;
      if (bf_cnt == 0 && bf_auto) bellman_done = 1'b1;
    end
    if (bellman_reset) bf_dly = 2;
    if (cd_dly > 0) begin
      cd_dly--;
      if (cd_dly == 0) begin cycle_done = 1'b0; cd_cnt = cd_lat; end
    end else if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) cycle_done = 1'b1;
    end
    if (cycle_reset) cd_dly = 2;
  endtask

  task automatic push(input int s, input int d, input logic [31:0] w);
    upd_valid = 1'b1; upd_src = 6'(s); upd_dst = 6'(d); upd_w = w;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < budget);
    check(tag, busy, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, upd_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_we"}, adj_we, 1'b0);
    check({tag, "_rowcol"}, {adj_row, adj_col}, 0);
    check({tag, "_data"}, adj_data, 0);
    check({tag, "_pulses"}, {bellman_reset, cycle_reset, run_done}, 0);
    check({tag, "_tout"}, run_timeout, 1'b0);
    check({tag, "_drop"}, drop_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    ctrl_reset = 1'b1; upd_valid = 1'b0; upd_src = '0; upd_dst = '0; upd_w = '0;
    bellman_done = 1'b0; cycle_done = 1'b0;
    bellman_row = 6'd12; bellman_col = 6'd13; cycle_row = 6'd9; cycle_col = 6'd11;
    bf_auto = 1'b1; bf_dly = 0; bf_cnt = 0; cd_dly = 0; cd_cnt = 0;
    tick(); tick();
    ctrl_reset = 1'b0;
    clear_log();
    check_reset("rst");

    // T1: single update, exact run timeline
    push(3, 7, 100);
    check("t1_first_we", adj_we, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 5) begin
        check("t1_bf_mux", {adj_we, adj_row, adj_col}, {1'b0, 6'd12, 6'd13});
      end
      if (i == 11) check("t1_cd_mux", {adj_row, adj_col}, {6'd9, 6'd11});
      if (i == 14) check("t1_run_done", run_done, 1'b1);
    end
    check("t1_idle", busy, 1'b0);
    check("t1_nwr", wr_rc.size(), 2);
    check("t1_fwd_rc", wr_rc[0], 3 * 64 + 7);
    check("t1_fwd_d", wr_d[0], 100);
    check("t1_rev_rc", wr_rc[1], 7 * 64 + 3);
    check("t1_rev_d", wr_d[1], 32'hFFFF_FF9C);
    check("t1_counts", {8'(n_bf), 8'(n_cd), 8'(n_done)}, {8'd1, 8'd1, 8'd1});

    // T1b: same update with stale done levels from the previous run
    clear_log();
    push(3, 7, 100);
    wait_idle("t1b_idle", 40, n);
    check("t1b_len", n, 15);
    check("t1b_done", n_done, 1);

    // T2: six back-to-back updates split into batches of four
    clear_log();
    upd_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      upd_src = 6'(i + 1); upd_dst = 6'(i + 2); upd_w = 32'((i + 1) * 10);
      tick();
    end
    upd_valid = 1'b0;
    wait_idle("t2_idle", 200, n);
    check("t2_nwr", wr_rc.size(), 12);
    for (int k = 0; k < 6; k++) begin
      check("t2_fwd_rc", wr_rc[2*k], (k + 1) * 64 + (k + 2));
      check("t2_fwd_d", wr_d[2*k], 32'((k + 1) * 10));
      check("t2_rev_rc", wr_rc[2*k+1], (k + 2) * 64 + (k + 1));
      check("t2_rev_d", wr_d[2*k+1], 32'(-(k + 1) * 10));
    end
    check("t2_bf_before_9th", {8'(wr_bf[7]), 8'(wr_bf[8])}, {8'd0, 8'd1});
    check("t2_runs", {8'(n_bf), 8'(n_done)}, {8'd2, 8'd2});

    // T3: rejected updates
    clear_log();
    push(5, 5, 1);
    push(3, 40, 1);
    repeat (5) tick();
    check("t3_nwr", wr_rc.size(), 0);
    check("t3_drop", drop_count, 2);
    check("t3_no_run", n_bf, 0);
    check("t3_idle", busy, 1'b0);

    // T4: back-pressure while Bellman is held
    clear_log();
    bf_auto = 1'b0;
    push(10, 11, 1);
    repeat (3) tick();
    check("t4_in_run", busy, 1'b1);
    upd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      upd_src = 6'(i); upd_dst = 6'(i + 20); upd_w = 32'(i + 1000);
      tick();
    end
    check("t4_full", upd_ready, 1'b0);
    upd_src = 6'd30; upd_dst = 6'd31; upd_w = 32'd5000;
    tick();
    check("t4_still_full", upd_ready, 1'b0);
    upd_valid = 1'b0;
    bf_auto = 1'b1;
    bellman_done = 1'b1;
    begin : t4_wait_ready
      int k;
      k = 0;
      while (!upd_ready && k < 50) begin tick(); k++; end
    end
    check("t4_ready_rise", upd_ready, 1'b1);
    wait_idle("t4_idle", 400, n);
    check("t4_nwr", wr_rc.size(), 18);
    check("t4_first_rc", wr_rc[2], 0 * 64 + 20);
    check("t4_last_rc", wr_rc[16], 7 * 64 + 27);
    check("t4_last_d", wr_d[17], 32'(-1007));
    check("t4_runs", n_done, 3);

    // T5: watchdog
    clear_log();
    bf_auto = 1'b0;
    push(1, 2, 5);
    repeat (103) tick();
    check("t5_pre_tout", {run_timeout, busy}, 2'b01);
    tick();
    check("t5_tout", {run_timeout, run_done}, 2'b11);
    tick();
    check("t5_no_cd", n_cd, 0);
    check("t5_idle", busy, 1'b0);
    repeat (3) tick();
    check("t5_sticky", run_timeout, 1'b1);
    bf_auto = 1'b1;

    // T6: most-negative weight, then reset during RUN_CD
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    bellman_done = 1'b0; cycle_done = 1'b0;
    bf_dly = 0; bf_cnt = 0; cd_dly = 0; cd_cnt = 0;
    clear_log();
    push(1, 2, 32'h8000_0000);
    tick();
    check("t6_fwd_d", wr_d[0], 32'h8000_0000);
    check("t6_rev_sat", wr_d[1], 32'h7FFF_FFFF);
    begin : t6_wait_cd
      int k;
      k = 0;
      while (n_cd == 0 && k < 30) begin tick(); k++; end
    end
    check("t6_cd_start", n_cd, 1);
    tick();
    check("t6_in_cd", {adj_row, adj_col}, {6'd9, 6'd11});
    ctrl_reset = 1'b1;
    tick();
    ctrl_reset = 1'b0;
    check_reset("t6_rst");

    // T7: instance without CycleDetect
    bellman_done = 1'b0; cycle_done = 1'b0;
    bf_dly = 0; bf_cnt = 0; cd_dly = 0; cd_cnt = 0;
    clear_log();
    push(2, 9, 7);
    begin : t7_wait_bf
      int k;
      k = 0;
      while (!bellman_done && k < 30) begin tick(); k++; end
    end
    check("t7_bf_done", bellman_done, 1'b1);
    tick();
    check("t7_done_next", done_nc, 1'b1);
    wait_idle("t7_idle", 60, n);
    check("t7_done_once", n_done_nc, 1);
    check("t7_no_cd", n_cd_nc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
